// File: rtl/dmem_mmio_responder.sv
`timescale 1ns/1ps
// Data-memory bus responder: a word-addressed RAM plus a memory-mapped bank
// holding a GPIO output, a synchronized GPIO input and a compare timer.
module dmem_mmio_responder #(
  parameter int          RAM_WORDS   = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          GPIO_W      = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              memwrite,
  input  logic [31:0]       memaddr,
  input  logic [31:0]       memwritedata,
  output logic [31:0]       memreaddata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN  = 6'h01;
  localparam logic [5:0] OFF_CTRL     = 6'h02;
  localparam logic [5:0] OFF_COUNT    = 6'h03;
  localparam logic [5:0] OFF_CMP      = 6'h04;
  localparam logic [5:0] OFF_STATUS   = 6'h05;

  logic [31:0]       ram [RAM_WORDS];
  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];

  logic              ram_sel;
  logic              mmio_sel;
  logic [AW-1:0]     ram_idx;
  logic [5:0]        reg_off;
  logic              unused_addr_lsbs;

  logic              wr_mmio;
  logic              wr_gpio;
  logic              wr_ctrl;
  logic              wr_count;
  logic              wr_cmp;
  logic              wr_status;

  logic              en;
  logic              autoreload;
  logic              irq_en;
  logic [31:0]       count;
  logic [31:0]       cmp;
  logic              match_flag;
  logic              match;

  logic [31:0]       gpo_ext;
  logic [31:0]       gpi_ext;

  assign ram_sel          = (memaddr[31:AW+2] == '0);
  assign ram_idx          = memaddr[AW+1:2];
  assign mmio_sel         = (memaddr[31:16] == MMIO_BASE[31:16]);
  assign reg_off          = memaddr[7:2];
  assign unused_addr_lsbs = ^memaddr[1:0];

  assign wr_mmio   = memwrite && mmio_sel && !ram_sel;
  assign wr_gpio   = wr_mmio && (reg_off == OFF_GPIO_OUT);
  assign wr_ctrl   = wr_mmio && (reg_off == OFF_CTRL);
  assign wr_count  = wr_mmio && (reg_off == OFF_COUNT);
  assign wr_cmp    = wr_mmio && (reg_off == OFF_CMP);
  assign wr_status = wr_mmio && (reg_off == OFF_STATUS);

  // A COUNT load takes precedence over the compare, so it also masks the match.
  assign match = en && (count == cmp) && !wr_count;

  assign timer_irq = match_flag && irq_en;

  always_ff @(posedge clk) begin
    if (memwrite && ram_sel) begin
      ram[ram_idx] <= memwritedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_out   <= '0;
      en         <= 1'b0;
      autoreload <= 1'b0;
      irq_en     <= 1'b0;
      count      <= '0;
      cmp        <= '1;
      match_flag <= 1'b0;
    end else begin
      if (wr_gpio) begin
        gpio_out <= memwritedata[GPIO_W-1:0];
      end
      if (wr_cmp) begin
        cmp <= memwritedata;
      end

      // A CTRL write overrides the one-shot auto-disable on a match cycle.
      if (wr_ctrl) begin
        en         <= memwritedata[0];
        autoreload <= memwritedata[1];
        irq_en     <= memwritedata[2];
      end else if (match && !autoreload) begin
        en <= 1'b0;
      end

      if (wr_count) begin
        count <= memwritedata;
      end else if (match) begin
        if (autoreload) begin
          count <= '0;
        end
      end else if (en) begin
        count <= count + 32'd1;
      end

      // Set beats a simultaneous W1C so a match is never lost.
      if (match) begin
        match_flag <= 1'b1;
      end else if (wr_status && memwritedata[0]) begin
        match_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    gpo_ext                = '0;
    gpo_ext[GPIO_W-1:0]    = gpio_out;
    gpi_ext                = '0;
    gpi_ext[GPIO_W-1:0]    = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    memreaddata = '0;
    if (ram_sel) begin
      memreaddata = ram[ram_idx];
    end else if (mmio_sel) begin
      case (reg_off)
        OFF_GPIO_OUT: memreaddata = gpo_ext;
        OFF_GPIO_IN:  memreaddata = gpi_ext;
        OFF_CTRL:     memreaddata = {29'b0, irq_en, autoreload, en};
        OFF_COUNT:    memreaddata = count;
        OFF_CMP:      memreaddata = cmp;
        OFF_STATUS:   memreaddata = {31'b0, match_flag};
        default:      memreaddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
`timescale 1ns/1ps
// Directed bench for dmem_mmio_responder: stimulus queues expected values,
// a negedge monitor pops and compares them against the live outputs.
module tb_dmem_mmio_responder;

  localparam logic [31:0] B      = 32'hFFFF_0000;
  localparam logic [31:0] A_GPO  = B;
  localparam logic [31:0] A_GPI  = B + 32'd4;
  localparam logic [31:0] A_CTRL = B + 32'd8;
  localparam logic [31:0] A_CNT  = B + 32'd12;
  localparam logic [31:0] A_CMP  = B + 32'd16;
  localparam logic [31:0] A_ST   = B + 32'd20;

  localparam int SEL_RD  = 0;
  localparam int SEL_GPO = 1;
  localparam int SEL_IRQ = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        timer_irq;

  dmem_mmio_responder #(
    .RAM_WORDS  (64),
    .MMIO_BASE  (32'hFFFF_0000),
    .GPIO_W     (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .memwrite    (memwrite),
    .memaddr     (memaddr),
    .memwritedata(memwritedata),
    .memreaddata (memreaddata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .timer_irq   (timer_irq)
  );

  always #5 clk = ~clk;

  string       nq[$];
  int          sq[$];
  logic [31:0] eq[$];
  int          chk_n  = 0;
  int          n_run  = 0;
  int          n_fail = 0;

  always @(negedge clk) begin : monitor
    string       nm;
    int          s;
    logic [31:0] e;
    logic [31:0] act;
    for (int i = 0; i < chk_n; i++) begin
      if (nq.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue, want an expected entry");
      end else begin
        nm = nq.pop_front();
        s  = sq.pop_front();
        e  = eq.pop_front();
        case (s)
          SEL_RD:  act = memreaddata;
          SEL_GPO: act = 32'(gpio_out);
          default: act = {31'b0, timer_irq};
        endcase
        n_run++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %08h, want %08h", nm, act, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int s, input logic [31:0] e);
    nq.push_back(nm);
    sq.push_back(s);
    eq.push_back(e);
    chk_n++;
  endtask

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    memwrite     = we;
    memaddr      = a;
    memwritedata = d;
    @(posedge clk);
    #1;
    chk_n    = 0;
    memwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, d);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk(nm, SEL_RD, e);
    cyc(1'b0, a, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, A_CNT, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    memwrite     = 1'b0;
    memaddr      = '0;
    memwritedata = '0;
    gpio_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // reset state
    chk("rst_irq", SEL_IRQ, 32'h0);
    chk("rst_gpo_pin", SEL_GPO, 32'h0);
    rd("rst_gpio_out", A_GPO, 32'h0);
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_count", A_CNT, 32'h0);
    rd("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rd("rst_status", A_ST, 32'h0);

    // RAM and decode
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_00FC, 32'h1234_5678);
    wr(32'h0000_0000, 32'h0000_0000);
    wr(32'h0000_0100, 32'hBAD0_BAD0);
    wr(32'h0001_0000, 32'h0000_0055);
    rd("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_fc", 32'h0000_00FC, 32'h1234_5678);
    rd("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
    rd("unmapped_100", 32'h0000_0100, 32'h0);
    rd("ram_0_no_alias", 32'h0000_0000, 32'h0);
    rd("unmapped_10000", 32'h0001_0000, 32'h0);
    rd("mmio_hole", B + 32'h18, 32'h0);
    chk("ram_rd_during_wr", SEL_RD, 32'hDEAD_BEEF);
    cyc(1'b1, 32'h0000_0010, 32'h1111_1111);
    rd("ram_10_new", 32'h0000_0010, 32'h1111_1111);

    // GPIO
    wr(A_GPO, 32'hFFFF_A5A5);
    chk("gpio_out_pin", SEL_GPO, 32'h0000_A5A5);
    rd("gpio_out_rd", A_GPO, 32'h0000_A5A5);
    gpio_in = 16'h0F0F;
    rd("gpio_in_c0", A_GPI, 32'h0);
    rd("gpio_in_c1", A_GPI, 32'h0);
    rd("gpio_in_c2", A_GPI, 32'h0000_0F0F);
    wr(A_GPI, 32'h0);
    rd("gpio_in_ro", A_GPI, 32'h0000_0F0F);
    wr(A_CTRL, 32'hFFFF_FFFA);
    rd("ctrl_mask", A_CTRL, 32'h2);

    // one-shot
    wr(A_CTRL, 32'h0);
    wr(A_CNT, 32'h0);
    wr(A_CMP, 32'h5);
    wr(A_CTRL, 32'h5);
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("os_irq_c%0d", i), SEL_IRQ, 32'h0);
      rd($sformatf("os_flag_c%0d", i), A_ST, 32'h0);
    end
    chk("os_irq_set", SEL_IRQ, 32'h1);
    rd("os_flag_set", A_ST, 32'h1);
    rd("os_count_hold", A_CNT, 32'h5);
    rd("os_ctrl", A_CTRL, 32'h4);
    rd("os_count_hold2", A_CNT, 32'h5);
    wr(A_ST, 32'h0);
    rd("status_w0", A_ST, 32'h1);
    wr(A_ST, 32'h1);
    chk("irq_cleared", SEL_IRQ, 32'h0);
    rd("status_w1c", A_ST, 32'h0);

    // autoreload
    wr(A_CNT, 32'h0);
    wr(A_CMP, 32'h3);
    wr(A_CTRL, 32'h3);
    for (int i = 1; i <= 4; i++) begin
      rd($sformatf("ar_flag_c%0d", i), A_ST, 32'h0);
    end
    rd("ar_set1", A_ST, 32'h1);
    chk("ar_w1c_old", SEL_RD, 32'h1);
    cyc(1'b1, A_ST, 32'h1);
    rd("ar_cleared", A_ST, 32'h0);
    chk("ar_w1c_match_old", SEL_RD, 32'h0);
    cyc(1'b1, A_ST, 32'h1);
    chk("ar_irq_masked", SEL_IRQ, 32'h0);
    rd("ar_set_wins", A_ST, 32'h1);
    rd("ar_reloaded", A_CNT, 32'h1);
    wr(A_CTRL, 32'h0);
    wr(A_ST, 32'h1);

    // wrap
    wr(A_CMP, 32'h1);
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h1);
    rd("wrap_c1", A_CNT, 32'hFFFF_FFFE);
    rd("wrap_c2", A_CNT, 32'hFFFF_FFFF);
    rd("wrap_c3", A_CNT, 32'h0);
    rd("wrap_c4", A_CNT, 32'h1);
    rd("wrap_set", A_ST, 32'h1);
    rd("wrap_en_clr", A_CTRL, 32'h0);
    wr(A_ST, 32'h1);

    // COUNT write beats match
    wr(A_CNT, 32'h0);
    wr(A_CMP, 32'h2);
    wr(A_CTRL, 32'h1);
    idle();
    idle();
    wr(A_CNT, 32'h100);
    rd("prio_count", A_CNT, 32'h100);
    rd("prio_flag", A_ST, 32'h0);
    rd("prio_en_kept", A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0);

    // CTRL write on a one-shot match
    wr(A_CNT, 32'h0);
    wr(A_CMP, 32'h1);
    wr(A_CTRL, 32'h5);
    idle();
    wr(A_CTRL, 32'h7);
    chk("coll_irq", SEL_IRQ, 32'h1);
    rd("coll_flag", A_ST, 32'h1);
    rd("coll_ctrl", A_CTRL, 32'h7);
    wr(A_CTRL, 32'h0);
    wr(A_ST, 32'h1);

    // asynchronous reset mid-count
    wr(A_CNT, 32'h0);
    wr(A_CMP, 32'h3);
    wr(A_CTRL, 32'h7);
    repeat (4) idle();
    chk("pre_rst_irq", SEL_IRQ, 32'h1);
    rd("pre_rst_flag", A_ST, 32'h1);
    reset_n = 1'b0;
    chk("rst_async_irq", SEL_IRQ, 32'h0);
    chk("rst_async_gpo", SEL_GPO, 32'h0);
    rd("rst_async_cmp", A_CMP, 32'hFFFF_FFFF);
    rd("rst_ctrl2", A_CTRL, 32'h0);
    rd("rst_count2", A_CNT, 32'h0);
    rd("rst_status2", A_ST, 32'h0);
    rd("rst_gpio_in", A_GPI, 32'h0);
    rd("ram_kept", 32'h0000_00FC, 32'h1234_5678);
    reset_n = 1'b1;
    rd("post_rst_gpo", A_GPO, 32'h0);

    if (nq.size() != 0) begin
      n_run  += nq.size();
      n_fail += nq.size();
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, want 0", nq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
